// File: rtl/sha3_padder.sv
// rtl/sha3_padder.sv - SHA-3 rate-block assembler with Keccak multi-rate padding
//
// Purpose: collects 32-bit big-endian message words into a 576-bit (18-word)
// rate block, appends 0x01 .. 0x80 padding after the final message byte and
// presents each complete block to the permutation stage.
//
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous active-high reset, clears all state
//   in[31:0]     message word, byte 0 in in[31:24]
//   in_ready     in is valid this cycle
//   is_last      final word of the message (qualified by in_ready)
//   byte_num     valid bytes in the final word (0..3)
//   buffer_full  padder cannot accept a word this cycle (registered)
//   out[575:0]   assembled block, word 0 at out[575:544]
//   out_ready    out holds a complete block
//   f_ack        permutation stage consumed out this cycle

module sha3_padder (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in,
  input  logic         in_ready,
  input  logic         is_last,
  input  logic [1:0]   byte_num,
  output logic         buffer_full,
  output logic [575:0] out,
  output logic         out_ready,
  input  logic         f_ack
);

  localparam logic [4:0] WORDS = 5'd18;

  logic [4:0]  cnt;
  logic        pad;
  logic        done;

  logic [4:0]  cnt_n;
  logic        pad_n;
  logic        done_n;
  logic        wr;
  logic [31:0] w;
  logic [31:0] padded;
  logic        accept;
  logic        last_pos;
  logic        full;

  assign full     = (cnt == WORDS);
  assign last_pos = (cnt == 5'd17);
  // buffer_full already covers FULL, PAD and DONE, so accept only fires in ACCUM.
  assign accept   = in_ready & ~buffer_full;

  // Final message word: keep the valid bytes, put the 0x01 pad byte right after
  // them; any bytes beyond byte_num are dropped.
  always_comb begin
    padded = 32'h0100_0000;
    case (byte_num)
      2'd0: padded = 32'h0100_0000;
      2'd1: padded = {in[31:24], 24'h01_0000};
      2'd2: padded = {in[31:16], 16'h0100};
      2'd3: padded = {in[31:8], 8'h01};
      default: padded = 32'h0100_0000;
    endcase
  end

  always_comb begin
    wr     = 1'b0;
    w      = 32'h0;
    cnt_n  = cnt;
    pad_n  = pad;
    done_n = done;
    if (full) begin
      if (f_ack) begin
        cnt_n = 5'd0;
      end
    end else if (pad) begin
      // Padding fill: zero words, with the closing 0x80 in the last slot.
      wr    = 1'b1;
      w     = last_pos ? 32'h0000_0080 : 32'h0;
      cnt_n = cnt + 5'd1;
      if (last_pos) begin
        pad_n  = 1'b0;
        done_n = 1'b1;
      end
    end else if (accept) begin
      wr    = 1'b1;
      cnt_n = cnt + 5'd1;
      if (is_last) begin
        if (last_pos) begin
          // Both pad bytes land in the same word; no fill phase needed.
          w      = padded | 32'h0000_0080;
          done_n = 1'b1;
        end else begin
          w     = padded;
          pad_n = 1'b1;
        end
      end else begin
        w = in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out         <= '0;
      cnt         <= 5'd0;
      pad         <= 1'b0;
      done        <= 1'b0;
      out_ready   <= 1'b0;
      buffer_full <= 1'b0;
    end else begin
      if (wr) begin
        out <= {out[543:0], w};
      end
      cnt         <= cnt_n;
      pad         <= pad_n;
      done        <= done_n;
      // Flags are computed from next-state so they line up with cnt/pad/done
      // without a combinational path from in_ready.
      out_ready   <= (cnt_n == WORDS);
      buffer_full <= (cnt_n == WORDS) | pad_n | done_n;
    end
  end

endmodule
